chan_reg_file: RTL and testbench

Multi-channel successor to the single-value LCD register file. It holds NCH user-adjustable values of W bits each, edited with the rotary encoder and committed with the centre button. It continuously refreshes a two-row character LCD over the rq/ack handshake with the current edit value and all committed channel values. The block sits between the encoder/switch inputs and the LCD driver, and feeds the committed values (`val_add`) to the colour datapath.

---
 rtl/chan_reg_pkg.sv | 24 ++
 rtl/chan_reg_file_rot_dir_det.sv | 33 +++
 rtl/chan_reg_file.sv | 204 ++++++++++++++++++++
 tb/tb_chan_reg_file.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_reg_pkg.sv
// Shared constants, refresh FSM state type and the nibble-to-ASCII helper for chan_reg_file.
package chan_reg_pkg;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } lcd_state_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/chan_reg_file_rot_dir_det.sv
// Rotary encoder direction detector: one-cycle inc/dec pulses from phase rising edges.
module rot_dir_det (
    input  logic clk,
    input  logic reset,
    input  logic rot_s,
    input  logic rot_d,
    output logic inc,
    output logic dec
);

    logic r_s_d;
    logic r_d_d;
    logic w_s_rise;
    logic w_d_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_d <= 1'b0;
            r_d_d <= 1'b0;
        end else begin
            r_s_d <= rot_s;
            r_d_d <= rot_d;
        end
    end

    assign w_s_rise = rot_s & ~r_s_d;
    assign w_d_rise = rot_d & ~r_d_d;

    // Simultaneous edges cancel; each direction also needs the other phase low.
    assign inc = w_s_rise & ~w_d_rise & ~rot_d;
    assign dec = w_d_rise & ~w_s_rise & ~rot_s;

endmodule

// File: rtl/chan_reg_file.sv
// Multi-channel encoder-edited register file with continuous two-row LCD refresh.
// Optional saturating edit arithmetic when CHAN_REG_SAT_EN is defined (wraps otherwise).
//
// state | meaning
// LOAD  | latch row/column/character of current slot, raise rq_lcd
// WAIT  | hold LCD outputs until ack_lcd, then drop rq_lcd
// STEP  | advance slot pointer (rq_lcd low for this cycle)
module chan_reg_file
    import chan_reg_pkg::*;
#(
    parameter  int NCH = 3,
    parameter  int W   = 3,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      jp,
    input  logic              rot_s,
    input  logic              rot_d,
    input  logic              pres_c,
    output logic              rq_lcd,
    input  logic              ack_lcd,
    output logic              lcd_row,
    output logic [5:0]        lcd_column,
    output logic [7:0]        lcd_character,
    output logic [CW-1:0]     sel_ch,
    output logic [NCH*W-1:0]  val_add
);

    localparam int         DIG       = (W + 3) / 4;
    localparam logic [5:0] ROW0_LAST = 6'(4 + DIG);
    localparam logic [5:0] ROW1_LAST = 6'(NCH * (DIG + 1));

    logic             w_inc;
    logic             w_dec;
    logic             w_press;
    logic             r_pres_d;
    logic [W-1:0]     r_pending;
    logic [W-1:0]     r_val [NCH];
    logic [CW-1:0]    r_sel;
    logic [CW-1:0]    w_sel_nxt;
    logic [W-1:0]     w_val_nxt;
    logic [W-1:0]     w_pend_nxt;

    lcd_state_t       r_state;
    lcd_state_t       w_state_nxt;
    logic             w_load;
    logic             w_ack_take;
    logic             w_step;
    logic             r_ptr_row;
    logic [5:0]       r_ptr_col;
    logic [7:0]       w_char;
    logic             r_rq;
    logic             r_row;
    logic [5:0]       r_col;
    logic [7:0]       r_char;

    rot_dir_det u_rot (
        .clk   (clk),
        .reset (reset),
        .rot_s (rot_s),
        .rot_d (rot_d),
        .inc   (w_inc),
        .dec   (w_dec)
    );

    assign w_press   = pres_c & ~r_pres_d;
    assign w_sel_nxt = (r_sel == CW'(NCH - 1)) ? '0 : r_sel + 1'b1;
    // With a single channel the reloaded value is the one being committed.
    assign w_val_nxt = (w_sel_nxt == r_sel) ? r_pending : r_val[w_sel_nxt];

    always_comb begin
        w_pend_nxt = r_pending;
        if (w_inc) begin
`ifdef CHAN_REG_SAT_EN
            if (r_pending != {W{1'b1}})
                w_pend_nxt = r_pending + 1'b1;
`else
            w_pend_nxt = r_pending + 1'b1;
`endif
        end else if (w_dec) begin
`ifdef CHAN_REG_SAT_EN
            if (r_pending != '0)
                w_pend_nxt = r_pending - 1'b1;
`else
            w_pend_nxt = r_pending - 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pres_d  <= 1'b0;
            r_pending <= jp;
            r_sel     <= '0;
            for (int k = 0; k < NCH; k++)
                r_val[k] <= jp;
        end else begin
            r_pres_d <= pres_c;
            if (w_press) begin
                r_val[r_sel] <= r_pending;
                r_sel        <= w_sel_nxt;
                r_pending    <= w_val_nxt;
            end else begin
                r_pending    <= w_pend_nxt;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_pack
        assign val_add[k*W +: W] = r_val[k];
    end
    assign sel_ch = r_sel;

    always_comb begin
        logic [4*DIG-1:0] v_pad;
        v_pad  = (4*DIG)'(r_pending);
        w_char = ASCII_SP;
        if (!r_ptr_row) begin
            if (r_ptr_col == 6'd1)      w_char = ASCII_C;
            else if (r_ptr_col == 6'd2) w_char = ASCII_H;
            else if (r_ptr_col == 6'd3) w_char = ASCII_0 + 8'(r_sel);
            else if (r_ptr_col == 6'd4) w_char = ASCII_COLON;
            for (int d = 0; d < DIG; d++)
                if (r_ptr_col == 6'(5 + d))
                    w_char = hex2ascii(v_pad[4*(DIG-1-d) +: 4]);
        end else begin
            for (int k = 0; k < NCH; k++) begin
                v_pad = (4*DIG)'(r_val[k]);
                for (int j = 0; j < DIG; j++)
                    if (r_ptr_col == 6'(k*(DIG+1) + j + 1))
                        w_char = hex2ascii(v_pad[4*(DIG-1-j) +: 4]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= LOAD;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ack_take  = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (ack_lcd) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = STEP;
                end
            end
            STEP: begin
                w_step      = 1'b1;
                w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rq      <= 1'b0;
            r_row     <= 1'b0;
            r_col     <= 6'd1;
            r_char    <= ASCII_SP;
            r_ptr_row <= 1'b0;
            r_ptr_col <= 6'd1;
        end else begin
            if (w_load) begin
                r_rq   <= 1'b1;
                r_row  <= r_ptr_row;
                r_col  <= r_ptr_col;
                r_char <= w_char;
            end
            if (w_ack_take)
                r_rq <= 1'b0;
            if (w_step) begin
                if (!r_ptr_row && r_ptr_col == ROW0_LAST) begin
                    r_ptr_row <= 1'b1;
                    r_ptr_col <= 6'd1;
                end else if (r_ptr_row && r_ptr_col == ROW1_LAST) begin
                    r_ptr_row <= 1'b0;
                    r_ptr_col <= 6'd1;
                end else begin
                    r_ptr_col <= r_ptr_col + 6'd1;
                end
            end
        end
    end

    assign rq_lcd        = r_rq;
    assign lcd_row       = r_row;
    assign lcd_column    = r_col;
    assign lcd_character = r_char;

endmodule

// File: tb/tb_chan_reg_file.sv
// Scoreboard bench for chan_reg_file (NCH=3/W=3 main instance, NCH=1/W=8 display instance).
module tb_chan_reg_file;

    localparam int NCH   = 3;
    localparam int W     = 3;
    localparam int DIG   = 1;
    localparam int CW    = 2;
    localparam int MAXV  = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [W-1:0]     jp = 3'd5;
    logic             rot_s = 1'b0;
    logic             rot_d = 1'b0;
    logic             pres_c = 1'b0;
    logic             resp_ack = 1'b0;
    logic             man_ack = 1'b0;
    logic             ack_lcd;
    logic             rq_lcd;
    logic             lcd_row;
    logic [5:0]       lcd_column;
    logic [7:0]       lcd_character;
    logic [CW-1:0]    sel_ch;
    logic [NCH*W-1:0] val_add;

    logic             rq8;
    logic             ack8 = 1'b0;
    logic             row8;
    logic [5:0]       col8;
    logic [7:0]       ch8;
    logic [0:0]       sel8;
    logic [7:0]       val8;
    logic [7:0]       c5 = 8'h00;
    logic [7:0]       c6 = 8'h00;

    assign ack_lcd = resp_ack | man_ack;

    chan_reg_file #(.NCH(NCH), .W(W)) u_dut (
        .clk(clk), .reset(reset), .jp(jp), .rot_s(rot_s), .rot_d(rot_d), .pres_c(pres_c),
        .rq_lcd(rq_lcd), .ack_lcd(ack_lcd), .lcd_row(lcd_row), .lcd_column(lcd_column),
        .lcd_character(lcd_character), .sel_ch(sel_ch), .val_add(val_add)
    );

    chan_reg_file #(.NCH(1), .W(8)) u_dut8 (
        .clk(clk), .reset(reset), .jp(8'hA3), .rot_s(1'b0), .rot_d(1'b0), .pres_c(1'b0),
        .rq_lcd(rq8), .ack_lcd(ack8), .lcd_row(row8), .lcd_column(col8),
        .lcd_character(ch8), .sel_ch(sel8), .val_add(val8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ack8 <= rq8 && !ack8;
        if (rq8 && !row8 && col8 == 6'd5) c5 <= ch8;
        if (rq8 && !row8 && col8 == 6'd6) c6 <= ch8;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int m_pend;
    int m_sel;
    int m_val [NCH];

    function automatic int m_packed();
        int r = 0;
        for (int k = 0; k < NCH; k++) r |= m_val[k] << (k * W);
        return r;
    endfunction

    function automatic int m_inc(input int p);
`ifdef CHAN_REG_SAT_EN
        return (p == MAXV) ? p : p + 1;
`else
        return (p + 1) % (MAXV + 1);
`endif
    endfunction

    function automatic int m_dec(input int p);
`ifdef CHAN_REG_SAT_EN
        return (p == 0) ? 0 : p - 1;
`else
        return (p + MAXV) % (MAXV + 1);
`endif
    endfunction

    function automatic int hexc(input int n);
        return (n < 10) ? 8'h30 + n : 8'h41 + n - 10;
    endfunction

    typedef struct { string tag; int sel; int val; } st_exp_t;
    typedef struct { int row; int col; int ch; } lcd_exp_t;
    st_exp_t  sq [$];
    lcd_exp_t lq [$];

    task automatic push_state(input string tag);
        sq.push_back('{tag, m_sel, m_packed()});
    endtask

    task automatic drain_state();
        st_exp_t e;
        while (sq.size() > 0) begin
            e = sq.pop_front();
            chk({e.tag, "_sel"}, int'(sel_ch), e.sel);
            chk({e.tag, "_val"}, int'(val_add), e.val);
        end
    endtask

    // LCD responder: acks each request two cycles after seeing it, comparing against the queue.
    bit ack_en = 0, sb_arm = 0, sb_run = 0, resp_busy = 0;
    initial begin
        lcd_exp_t le;
        forever begin
            @(negedge clk);
            if (ack_en && rq_lcd && !reset) begin
                resp_busy = 1;
                if (sb_arm && !sb_run && !lcd_row && lcd_column == 6'd1) sb_run = 1;
                if (sb_run && lq.size() > 0) begin
                    le = lq.pop_front();
                    chk($sformatf("lcd_row_r%0dc%0d", le.row, le.col), int'(lcd_row), le.row);
                    chk($sformatf("lcd_col_r%0dc%0d", le.row, le.col), int'(lcd_column), le.col);
                    chk($sformatf("lcd_chr_r%0dc%0d", le.row, le.col), int'(lcd_character), le.ch);
                    if (lq.size() == 0) begin
                        sb_run = 0;
                        sb_arm = 0;
                    end
                end
                repeat (2) @(negedge clk);
                resp_ack = 1'b1;
                @(negedge clk);
                resp_ack = 1'b0;
                resp_busy = 0;
            end
        end
    end

    task automatic check_screen(input string tag);
        lq.delete();
        lq.push_back('{0, 1, 8'h43});
        lq.push_back('{0, 2, 8'h48});
        lq.push_back('{0, 3, 8'h30 + m_sel});
        lq.push_back('{0, 4, 8'h3A});
        lq.push_back('{0, 5, hexc(m_pend)});
        for (int k = 0; k < NCH; k++) begin
            lq.push_back('{1, k*(DIG+1) + 1, hexc(m_val[k])});
            lq.push_back('{1, k*(DIG+1) + 2, 8'h20});
        end
        sb_arm = 1;
        for (int c = 0; c < 600 && sb_arm; c++) @(negedge clk);
        chk({tag, "_sweep_left"}, lq.size(), 0);
        sb_arm = 0;
        sb_run = 0;
    endtask

    task automatic do_reset(input int v);
        @(negedge clk);
        jp = W'(v);
        reset = 1'b1;
        #1;
        chk("rst_rq", int'(rq_lcd), 0);
        chk("rst_row", int'(lcd_row), 0);
        chk("rst_col", int'(lcd_column), 1);
        chk("rst_chr", int'(lcd_character), 8'h20);
        m_pend = v;
        m_sel  = 0;
        for (int k = 0; k < NCH; k++) m_val[k] = v;
        push_state("rst");
        repeat (3) @(negedge clk);
        drain_state();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input logic s, input logic d, input logic p, input string tag);
        rot_s = s; rot_d = d; pres_c = p;
        if (p) begin
            m_val[m_sel] = m_pend;
            m_sel = (m_sel + 1) % NCH;
            m_pend = m_val[m_sel];
        end else if (s && !d) m_pend = m_inc(m_pend);
        else if (d && !s)     m_pend = m_dec(m_pend);
        push_state(tag);
        @(negedge clk);
        rot_s = 1'b0; rot_d = 1'b0; pres_c = 1'b0;
        @(negedge clk);
        drain_state();
    endtask

    task automatic press_hold(input int n, input string tag);
        pres_c = 1'b1;
        m_val[m_sel] = m_pend;
        m_sel = (m_sel + 1) % NCH;
        m_pend = m_val[m_sel];
        push_state(tag);
        repeat (n) @(negedge clk);
        pres_c = 1'b0;
        @(negedge clk);
        drain_state();
    endtask

    task automatic wait_rq(input string tag);
        for (int c = 0; c < 20 && !rq_lcd; c++) @(negedge clk);
        chk(tag, int'(rq_lcd), 1);
    endtask

    task automatic man_pulse();
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ok;
        repeat (3) @(negedge clk);
        do_reset(5);
        chk("preset_val", int'(val_add), 'h16D);
        ack_en = 1;
        check_screen("preset");

        do_op(1, 0, 0, "inc1");
        do_op(1, 0, 0, "inc2");
        check_screen("at7");
        do_op(1, 0, 0, "inc_top");
        check_screen("wrap_up");
        do_reset(0);
        do_op(0, 1, 0, "dec_bot");
        check_screen("wrap_dn");

        do_reset(2);
        for (int i = 0; i < 3; i++) do_op(1, 0, 0, "inc");
        do_op(0, 0, 1, "press");
        check_screen("commit");
        do_op(1, 0, 0, "inc3");
        press_hold(20, "hold");
        check_screen("hold");
        do_op(1, 1, 0, "both");
        check_screen("both");
        do_op(1, 0, 1, "press_inc");
        check_screen("press_inc");

        ack_en = 0;
        for (int c = 0; c < 20 && resp_busy; c++) @(negedge clk);
        chk("resp_idle", int'(resp_busy), 0);
        do_reset(4);
        wait_rq("first_rq");
        n_ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rq_lcd && !lcd_row && lcd_column == 6'd1 && lcd_character == 8'h43) n_ok++;
        end
        chk("hold50", n_ok, 50);
        man_pulse();
        chk("rq_drop", int'(rq_lcd), 0);
        wait_rq("rq_next");
        chk("next_col", int'(lcd_column), 2);
        chk("next_chr", int'(lcd_character), 8'h48);
        for (int i = 0; i < 20 && !lcd_row; i++) begin
            man_pulse();
            wait_rq("rq_step");
        end
        chk("at_row1", int'(lcd_row), 1);
        reset = 1'b1;
        #1;
        chk("rq_async", int'(rq_lcd), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_rq("rq_after_rst");
        chk("restart_row", int'(lcd_row), 0);
        chk("restart_col", int'(lcd_column), 1);
        chk("restart_chr", int'(lcd_character), 8'h43);

        repeat (120) @(negedge clk);
        chk("w8_val", int'(val8), 'hA3);
        chk("w8_msd", int'(c5), 8'h41);
        chk("w8_lsd", int'(c6), 8'h33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
